// File: rtl/dac_enc_pkg.sv
// Shared constants, cell-field types and the rotated thermometer mask helper
// for the segmented DAC encoder.
package dac_enc_pkg;

   localparam int N_THERM  = 17;
   localparam int N_BIN    = 6;
   localparam int CODE_W   = 11;
   localparam int CODE_MAX = N_THERM * 64 + 63;

   typedef logic [N_THERM-1:0] therm_t;
   typedef logic [N_BIN:0]     bin_t;
   typedef logic [4:0]         ptr_t;
   typedef logic [4:0]         n_t;

   // n consecutive cells starting at ptr, wrapping modulo N_THERM
   function automatic therm_t therm_rot(input n_t n, input ptr_t ptr);
      logic [N_THERM:0]     ramp;
      therm_t               fill;
      logic [2*N_THERM-1:0] dbl;
      ramp = ({{N_THERM{1'b0}}, 1'b1} << n) - 1'b1;
      fill = (n >= 5'(N_THERM)) ? '1 : ramp[N_THERM-1:0];
      dbl  = {fill, fill} << ptr;
      return dbl[2*N_THERM-1:N_THERM];
   endfunction

endpackage

// File: rtl/dac_dwa_ptr.sv
// Data-weighted-averaging rotation pointer: advances by n modulo N_THERM when adv is high.
// Registered, one cycle update; holds when adv is low. Compiled only with DAC_DWA_EN.
// No backpressure; adv is a qualified strobe from the encoder.
`ifdef DAC_DWA_EN
module dac_dwa_ptr
   import dac_enc_pkg::*;
(
   input  logic clkin,
   input  logic rst,
   input  logic adv,
   input  n_t   n,
   output ptr_t ptr
);

   logic [5:0] sum;
   logic [5:0] wrapped;

   // ptr <= 16 and n <= 17, so a single subtraction brings the sum back in range
   always_comb begin
      sum     = {1'b0, ptr} + {1'b0, n};
      wrapped = sum - 6'(N_THERM);
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         ptr <= '0;
      end else if (adv) begin
         ptr <= (sum >= 6'(N_THERM)) ? wrapped[4:0] : sum[4:0];
      end
   end

endmodule
`endif

// File: rtl/dac_segment_encoder.sv
// Saturating thermometer/binary split feeding DAC sync latches, DWA rotation under DAC_DWA_EN.
// Latency 2 cycles in_valid -> out_valid, one sample per cycle.
// No backpressure: outputs hold when idle, mute to 0/complement 1 while pdb is low.
module dac_segment_encoder
   import dac_enc_pkg::*;
(
   input  logic                clkin,
   input  logic                rst,
   input  logic                pdb,
   input  logic                in_valid,
   input  logic [CODE_W-1:0]   in_code,
   input  logic                red_lsb,
   output logic [N_THERM-1:0]  dataouttherm,
   output logic [N_THERM-1:0]  dataoutthermb,
   output logic [N_BIN:0]      dataoutbin,
   output logic [N_BIN:0]      dataoutbinb,
   output logic                out_valid,
   output logic                sat
);

   logic              s1_valid;
   logic              s1_sat;
   n_t                s1_n;
   logic [N_BIN-1:0]  s1_b;
   logic [CODE_W-1:0] clip;

   logic   muted;
   logic   load;
   ptr_t   ptr;
   therm_t therm_nxt;
   bin_t   bin_nxt;

   always_comb begin
      clip = (in_code > CODE_W'(CODE_MAX)) ? CODE_W'(CODE_MAX) : in_code;
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sat   <= 1'b0;
         s1_n     <= '0;
         s1_b     <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sat <= (in_code > CODE_W'(CODE_MAX));
            s1_n   <= clip[CODE_W-1:N_BIN];
            s1_b   <= clip[N_BIN-1:0];
         end
      end
   end

`ifdef DAC_DWA_EN
   dac_dwa_ptr u_ptr (
      .clkin (clkin),
      .rst   (rst),
      .adv   (s1_valid & pdb),
      .n     (s1_n),
      .ptr   (ptr)
   );
`else
   assign ptr = '0;
`endif

   // After a mute, reload from stage 1 even without a fresh sample
   always_comb begin
      therm_nxt = dataouttherm;
      bin_nxt   = dataoutbin;
      load      = pdb & (s1_valid | muted);
      if (!pdb) begin
         therm_nxt = '0;
         bin_nxt   = '0;
      end else if (load) begin
         therm_nxt = therm_rot(s1_n, ptr);
         bin_nxt   = {red_lsb, s1_b};
      end
   end

   // Complements come from the next-state value so both rails switch on the same edge
   always_ff @(posedge clkin) begin
      if (rst) begin
         dataouttherm  <= '0;
         dataoutthermb <= '1;
         dataoutbin    <= '0;
         dataoutbinb   <= '1;
         out_valid     <= 1'b0;
         sat           <= 1'b0;
         muted         <= 1'b0;
      end else begin
         dataouttherm  <= therm_nxt;
         dataoutthermb <= ~therm_nxt;
         dataoutbin    <= bin_nxt;
         dataoutbinb   <= ~bin_nxt;
         out_valid     <= s1_valid;
         sat           <= s1_valid & s1_sat & pdb;
         muted         <= ~pdb;
      end
   end

endmodule
